// File: rtl/dic_pkg.sv
// Shared types and constants for the MM:SS time datapath.
// Digits are BCD nibbles; tens digits top out at 5, ones digits at 9.
package dic_pkg;

    localparam logic [3:0] TENS_MAX            = 4'd5;
    localparam logic [3:0] ONES_MAX            = 4'd9;
    localparam logic [3:0] DIGIT_BLANK_DEFAULT = 4'hF;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } time_t;

    typedef enum logic {
        RING_IDLE = 1'b0,
        RING_ON   = 1'b1
    } ring_state_t;

    // Clamp a keyed digit to the legal range of its position.
    function automatic logic [3:0] sat_digit(input logic [3:0] v, input logic [3:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/dic_bcd_digit.sv
// One BCD counter digit: saturating load, increment on enable, wraps MAX->0.
// o_next exposes the value the digit takes at the next edge.
module dic_bcd_digit
    import dic_pkg::*;
#(
    parameter logic [3:0] MAX = ONES_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_ld,
    input  logic [3:0] i_ld_val,
    output logic [3:0] o_q,
    output logic [3:0] o_next,
    output logic       o_carry
);

    logic [3:0] r_q;
    logic [3:0] w_next;

    always_comb begin
        w_next = r_q;
        if (i_ld) begin
            w_next = sat_digit(i_ld_val, MAX);
        end else if (i_en) begin
            w_next = (r_q >= MAX) ? 4'd0 : r_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= 4'd0;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q     = r_q;
    assign o_next  = w_next;
    assign o_carry = i_en && (r_q >= MAX);

endmodule

// File: rtl/dic_time_datapath.sv
// MM:SS time/alarm datapath: 1 Hz counting, keyed digit loads, alarm match
// detection with a ring latch, and blanked display digit outputs.
module dic_time_datapath
    import dic_pkg::*;
#(
    parameter logic [3:0]  DIGIT_BLANK = DIGIT_BLANK_DEFAULT,
    parameter int unsigned RING_TICKS  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       dicRun,
    input  logic       ld_time,
    input  logic       ld_alarm,
    input  logic       dicLdMtens,
    input  logic       dicLdMones,
    input  logic       dicLdStens,
    input  logic       dicLdSones,
    input  logic [3:0] key_digit,
    input  logic       alarm_ena,
    input  logic       dicDspMtens,
    input  logic       dicDspMones,
    input  logic       dicDspStens,
    input  logic       dicDspSones,
    output logic [3:0] disp_mtens,
    output logic [3:0] disp_mones,
    output logic [3:0] disp_stens,
    output logic [3:0] disp_sones,
    output logic       alarm_hit,
    output logic       alarm_ring
);

    localparam logic [15:0] RING_LAST = (RING_TICKS > 0) ? 16'(RING_TICKS - 1) : 16'd0;

    logic        w_any_strobe;
    logic        w_time_ld;
    logic        w_alarm_ld;
    logic        w_adv;
    logic [3:0]  w_mt_q, w_mo_q, w_st_q, w_so_q;
    logic [3:0]  w_mt_n, w_mo_n, w_st_n, w_so_n;
    logic        w_so_carry, w_st_carry, w_mo_carry, w_mt_carry_unused;
    time_t       w_time;
    time_t       w_time_next;
    time_t       r_alarm;
    logic        r_hit;
    ring_state_t r_ring_state;
    logic [15:0] r_ring_cnt;

    assign w_any_strobe = dicLdMtens | dicLdMones | dicLdStens | dicLdSones;
    assign w_time_ld    = ld_time & w_any_strobe;
    assign w_alarm_ld   = ld_alarm & ~ld_time;
    // A time load swallows a coincident tick outright; it is never replayed.
    assign w_adv        = tick_1hz & dicRun & ~w_time_ld;

    dic_bcd_digit #(.MAX(ONES_MAX)) u_sones (
        .clk(clk), .rst(rst), .i_en(w_adv), .i_ld(ld_time & dicLdSones),
        .i_ld_val(key_digit), .o_q(w_so_q), .o_next(w_so_n), .o_carry(w_so_carry)
    );
    dic_bcd_digit #(.MAX(TENS_MAX)) u_stens (
        .clk(clk), .rst(rst), .i_en(w_so_carry), .i_ld(ld_time & dicLdStens),
        .i_ld_val(key_digit), .o_q(w_st_q), .o_next(w_st_n), .o_carry(w_st_carry)
    );
    dic_bcd_digit #(.MAX(ONES_MAX)) u_mones (
        .clk(clk), .rst(rst), .i_en(w_st_carry), .i_ld(ld_time & dicLdMones),
        .i_ld_val(key_digit), .o_q(w_mo_q), .o_next(w_mo_n), .o_carry(w_mo_carry)
    );
    dic_bcd_digit #(.MAX(TENS_MAX)) u_mtens (
        .clk(clk), .rst(rst), .i_en(w_mo_carry), .i_ld(ld_time & dicLdMtens),
        .i_ld_val(key_digit), .o_q(w_mt_q), .o_next(w_mt_n), .o_carry(w_mt_carry_unused)
    );

    assign w_time      = '{mt: w_mt_q, mo: w_mo_q, st: w_st_q, so: w_so_q};
    assign w_time_next = '{mt: w_mt_n, mo: w_mo_n, st: w_st_n, so: w_so_n};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alarm <= '0;
        end else if (w_alarm_ld) begin
            if (dicLdMtens) r_alarm.mt <= sat_digit(key_digit, TENS_MAX);
            if (dicLdMones) r_alarm.mo <= sat_digit(key_digit, ONES_MAX);
            if (dicLdStens) r_alarm.st <= sat_digit(key_digit, TENS_MAX);
            if (dicLdSones) r_alarm.so <= sat_digit(key_digit, ONES_MAX);
        end
    end

    // Only a counting step can produce a match, so the hit lands with the new time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= w_adv & alarm_ena & (w_time_next == r_alarm);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ring_state <= RING_IDLE;
            r_ring_cnt   <= 16'd0;
        end else if (!alarm_ena) begin
            r_ring_state <= RING_IDLE;
            r_ring_cnt   <= 16'd0;
        end else if ((r_ring_state == RING_ON) && (RING_TICKS > 0) && tick_1hz
                     && (r_ring_cnt == RING_LAST)) begin
            r_ring_state <= RING_IDLE;
            r_ring_cnt   <= 16'd0;
        end else if (r_hit) begin
            r_ring_state <= RING_ON;
            r_ring_cnt   <= 16'd0;
        end else if ((r_ring_state == RING_ON) && (RING_TICKS > 0) && tick_1hz) begin
            r_ring_cnt   <= r_ring_cnt + 16'd1;
        end
    end

    assign alarm_hit  = r_hit;
    assign alarm_ring = (r_ring_state == RING_ON);

    assign disp_mtens = dicDspMtens ? w_time.mt : DIGIT_BLANK;
    assign disp_mones = dicDspMones ? w_time.mo : DIGIT_BLANK;
    assign disp_stens = dicDspStens ? w_time.st : DIGIT_BLANK;
    assign disp_sones = dicDspSones ? w_time.so : DIGIT_BLANK;

endmodule

// File: tb/tb_dic_time_datapath.sv
// Bench for dic_time_datapath: time kept as a seconds count in a reference
// model, directed scenarios with literal expectations, then random traffic.
module tb_dic_time_datapath;

    localparam int RT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, dicRun, ld_time, ld_alarm;
    logic       dicLdMtens, dicLdMones, dicLdStens, dicLdSones;
    logic [3:0] key_digit;
    logic       alarm_ena;
    logic       dicDspMtens, dicDspMones, dicDspStens, dicDspSones;
    logic [3:0] disp_mtens, disp_mones, disp_stens, disp_sones;
    logic       alarm_hit, alarm_ring;

    int   m_sec;
    int   m_al[4];
    logic m_hit, m_ring;
    int   m_cnt;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dic_time_datapath #(.DIGIT_BLANK(4'hF), .RING_TICKS(RT)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .dicRun(dicRun),
        .ld_time(ld_time), .ld_alarm(ld_alarm),
        .dicLdMtens(dicLdMtens), .dicLdMones(dicLdMones),
        .dicLdStens(dicLdStens), .dicLdSones(dicLdSones),
        .key_digit(key_digit), .alarm_ena(alarm_ena),
        .dicDspMtens(dicDspMtens), .dicDspMones(dicDspMones),
        .dicDspStens(dicDspStens), .dicDspSones(dicDspSones),
        .disp_mtens(disp_mtens), .disp_mones(disp_mones),
        .disp_stens(disp_stens), .disp_sones(disp_sones),
        .alarm_hit(alarm_hit), .alarm_ring(alarm_ring)
    );

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_sec  = 0;
        m_al   = '{0, 0, 0, 0};
        m_hit  = 1'b0;
        m_ring = 1'b0;
        m_cnt  = 0;
    endtask

    // Reference behaviour for one clock edge, from the current inputs.
    task automatic model_step();
        int   d[4];
        logic stb[4];
        bit   tload, adv;
        int   new_sec, al_sec;
        logic new_hit;
        if (!rst) begin
            model_reset();
            return;
        end
        stb = '{dicLdMtens, dicLdMones, dicLdStens, dicLdSones};
        d = '{m_sec / 600, (m_sec / 60) % 10, (m_sec % 60) / 10, m_sec % 10};
        tload = ld_time && (stb[0] || stb[1] || stb[2] || stb[3]);
        adv = tick_1hz && dicRun && !tload;
        new_sec = m_sec;
        if (tload) begin
            for (int i = 0; i < 4; i++)
                if (stb[i]) d[i] = sat(int'(key_digit), (i % 2 == 0) ? 5 : 9);
            new_sec = d[0] * 600 + d[1] * 60 + d[2] * 10 + d[3];
        end else if (adv) begin
            new_sec = (m_sec + 1) % 3600;
        end
        al_sec = m_al[0] * 600 + m_al[1] * 60 + m_al[2] * 10 + m_al[3];
        new_hit = adv && alarm_ena && (new_sec == al_sec);
        if (!alarm_ena) begin
            m_ring = 1'b0;
            m_cnt  = 0;
        end else if (m_ring && tick_1hz && (m_cnt + 1 == RT)) begin
            m_ring = 1'b0;
            m_cnt  = 0;
        end else if (m_hit) begin
            m_ring = 1'b1;
            m_cnt  = 0;
        end else if (m_ring && tick_1hz) begin
            m_cnt = m_cnt + 1;
        end
        if (ld_alarm && !ld_time)
            for (int i = 0; i < 4; i++)
                if (stb[i]) m_al[i] = sat(int'(key_digit), (i % 2 == 0) ? 5 : 9);
        m_sec = new_sec;
        m_hit = new_hit;
    endtask

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [3:0] d0, d1, d2, d3;
        d0 = 4'(m_sec / 600);
        d1 = 4'((m_sec / 60) % 10);
        d2 = 4'((m_sec % 60) / 10);
        d3 = 4'(m_sec % 10);
        chk("disp_mtens", disp_mtens, dicDspMtens ? d0 : 4'hF);
        chk("disp_mones", disp_mones, dicDspMones ? d1 : 4'hF);
        chk("disp_stens", disp_stens, dicDspStens ? d2 : 4'hF);
        chk("disp_sones", disp_sones, dicDspSones ? d3 : 4'hF);
        chk("alarm_hit", {3'b0, alarm_hit}, {3'b0, m_hit});
        chk("alarm_ring", {3'b0, alarm_ring}, {3'b0, m_ring});
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic lit_time(input string nm, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] e);
        chk({nm, ".mt"}, disp_mtens, a);
        chk({nm, ".mo"}, disp_mones, b);
        chk({nm, ".st"}, disp_stens, c);
        chk({nm, ".so"}, disp_sones, e);
    endtask

    task automatic load_digits(input bit to_time, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] e);
        ld_time = to_time;
        ld_alarm = !to_time;
        dicLdMtens = 1'b1; key_digit = a; cyc(); dicLdMtens = 1'b0;
        dicLdMones = 1'b1; key_digit = b; cyc(); dicLdMones = 1'b0;
        dicLdStens = 1'b1; key_digit = c; cyc(); dicLdStens = 1'b0;
        dicLdSones = 1'b1; key_digit = e; cyc(); dicLdSones = 1'b0;
        ld_time = 1'b0;
        ld_alarm = 1'b0;
    endtask

    task automatic tick_pulse();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        tick_1hz = 0; dicRun = 0; ld_time = 0; ld_alarm = 0;
        dicLdMtens = 0; dicLdMones = 0; dicLdStens = 0; dicLdSones = 0;
        key_digit = 4'd0; alarm_ena = 0;
        dicDspMtens = 1; dicDspMones = 1; dicDspStens = 1; dicDspSones = 1;
        model_reset();
        #1 rst = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        lit_time("reset", 4'd0, 4'd0, 4'd0, 4'd0);
        chk("reset.ring", {3'b0, alarm_ring}, 4'd0);

        // Asynchronous reset while loaded and running.
        load_digits(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        lit_time("load1234", 4'd1, 4'd2, 4'd3, 4'd4);
        dicRun = 1'b1;
        #2 rst = 1'b0;
        #1 model_reset();
        lit_time("async_rst", 4'd0, 4'd0, 4'd0, 4'd0);
        chk("async_rst.ring", {3'b0, alarm_ring}, 4'd0);
        compare_all();
        cyc();
        rst = 1'b1;

        // Rollover through 59:59.
        load_digits(1'b1, 4'd5, 4'd9, 4'd5, 4'd8);
        tick_pulse(); lit_time("t5959", 4'd5, 4'd9, 4'd5, 4'd9);
        tick_pulse(); lit_time("t0000", 4'd0, 4'd0, 4'd0, 4'd0);
        tick_pulse(); lit_time("t0001", 4'd0, 4'd0, 4'd0, 4'd1);

        // Saturation, multi-strobe, ignored strobes, bank priority.
        ld_time = 1; dicLdMtens = 1; key_digit = 4'd9; cyc(); dicLdMtens = 0;
        lit_time("sat_mt", 4'd5, 4'd0, 4'd0, 4'd1);
        dicLdSones = 1; key_digit = 4'd7; cyc(); dicLdSones = 0;
        lit_time("ld_so7", 4'd5, 4'd0, 4'd0, 4'd7);
        {dicLdMtens, dicLdMones, dicLdStens, dicLdSones} = 4'hF; key_digit = 4'd8; cyc();
        lit_time("multi8", 4'd5, 4'd8, 4'd5, 4'd8);
        ld_time = 0; key_digit = 4'd1; cyc();
        lit_time("no_bank", 4'd5, 4'd8, 4'd5, 4'd8);
        {dicLdMtens, dicLdMones, dicLdStens, dicLdSones} = 4'h4;
        ld_time = 1; ld_alarm = 1; key_digit = 4'd2; cyc();
        {dicLdMtens, dicLdMones, dicLdStens, dicLdSones} = 4'h0; ld_time = 0; ld_alarm = 0;
        lit_time("both_bank", 4'd5, 4'd2, 4'd5, 4'd8);

        // Tick coincident with a time load is dropped.
        load_digits(1'b1, 4'd0, 4'd0, 4'd0, 4'd5);
        tick_1hz = 1; ld_time = 1; dicLdSones = 1; key_digit = 4'd3; cyc();
        tick_1hz = 0; ld_time = 0; dicLdSones = 0;
        lit_time("drop_tick", 4'd0, 4'd0, 4'd0, 4'd3);
        tick_pulse(); lit_time("after_drop", 4'd0, 4'd0, 4'd0, 4'd4);

        // Alarm hit and ring cleared by disarm.
        alarm_ena = 1;
        load_digits(1'b0, 4'd0, 4'd0, 4'd0, 4'd3);
        load_digits(1'b1, 4'd0, 4'd0, 4'd0, 4'd2);
        tick_1hz = 1; cyc(); tick_1hz = 0;
        chk("hit_pulse", {3'b0, alarm_hit}, 4'd1);
        lit_time("hit_time", 4'd0, 4'd0, 4'd0, 4'd3);
        cyc();
        chk("hit_drop", {3'b0, alarm_hit}, 4'd0);
        chk("ring_set", {3'b0, alarm_ring}, 4'd1);
        cyc();
        chk("ring_hold", {3'b0, alarm_ring}, 4'd1);
        alarm_ena = 0; cyc();
        chk("ring_clr", {3'b0, alarm_ring}, 4'd0);

        // Ring auto-clears after RT further ticks.
        alarm_ena = 1;
        load_digits(1'b0, 4'd0, 4'd0, 4'd0, 4'd5);
        load_digits(1'b1, 4'd0, 4'd0, 4'd0, 4'd4);
        tick_1hz = 1; cyc(); tick_1hz = 0; cyc();
        chk("ring2_set", {3'b0, alarm_ring}, 4'd1);
        tick_pulse(); tick_pulse();
        chk("ring_2ticks", {3'b0, alarm_ring}, 4'd1);
        tick_pulse();
        chk("ring_3ticks", {3'b0, alarm_ring}, 4'd0);
        lit_time("ring_time", 4'd0, 4'd0, 4'd0, 4'd8);

        // Alarm load does not block a tick.
        ld_alarm = 1; dicLdSones = 1; key_digit = 4'd9; tick_1hz = 1; cyc();
        ld_alarm = 0; dicLdSones = 0; tick_1hz = 0;
        lit_time("alarm_ld_tick", 4'd0, 4'd0, 4'd0, 4'd9);
        alarm_ena = 0;

        // Frozen while not running; blanking.
        dicRun = 0;
        repeat (3) tick_pulse();
        lit_time("frozen", 4'd0, 4'd0, 4'd0, 4'd9);
        dicDspStens = 0; cyc();
        chk("blank_st", disp_stens, 4'hF);
        chk("blank_so", disp_sones, 4'd9);
        dicDspStens = 1;

        for (int n = 0; n < 3000; n++) begin
            tick_1hz  = ($urandom_range(0, 2) == 0);
            dicRun    = ($urandom_range(0, 7) != 0);
            ld_time   = ($urandom_range(0, 9) == 0);
            ld_alarm  = ($urandom_range(0, 9) == 0);
            {dicLdMtens, dicLdMones, dicLdStens, dicLdSones} =
                4'($urandom_range(0, 15) & $urandom_range(0, 15));
            key_digit = 4'($urandom_range(0, 15));
            alarm_ena = ($urandom_range(0, 31) != 0);
            {dicDspMtens, dicDspMones, dicDspStens, dicDspSones} =
                4'($urandom_range(0, 15) | $urandom_range(0, 15) | $urandom_range(0, 15));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
